// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a 32-bit immediate into the RV32I I/S/B/J/U
// immediate fields of a base instruction word and flags values that the chosen
// format cannot represent. The result passes through a two-stage valid/ready
// pipeline with full backpressure. A saturating counter tracks erroneous
// results as they are consumed.
module imm_encoder #(
    parameter int unsigned WIDTH     = 32,  // only 32 is supported
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           Immsrc,
    input  logic [WIDTH-1:0]     imm,
    input  logic [WIDTH-1:0]     base_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     instr_out,
    output logic                 range_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Immediate format codes carried on Immsrc
    typedef enum logic [2:0] {
        FmtI = 3'b000,
        FmtS = 3'b001,
        FmtB = 3'b010,
        FmtJ = 3'b011,
        FmtU = 3'b100
    } imm_fmt_e;

    // ------------------------------------------------------------------
    // Combinational encoder
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] enc_word;
    logic             enc_err;

    // Representability checks: the bits above the top field bit must be a
    // pure sign extension of that bit, and branch/jump offsets must be even.
    logic fits_12;   // I and S: imm[31:11] uniform
    logic fits_13;   // B: imm[31:12] uniform
    logic fits_21;   // J: imm[31:20] uniform
    logic low_zero;  // U: imm[11:0] clear

    // Range predicates shared by the encoder
    always_comb begin
        fits_12  = (&imm[31:11]) || !(|imm[31:11]);
        fits_13  = (&imm[31:12]) || !(|imm[31:12]);
        fits_21  = (&imm[31:20]) || !(|imm[31:20]);
        low_zero = !(|imm[11:0]);
    end

    // Scatter the immediate into the format fields; base bits elsewhere pass
    // through. Truncated bits are still written when the value is out of range.
    always_comb begin
        enc_word = base_instr;
        enc_err  = 1'b0;
        case (imm_fmt_e'(Immsrc))
            FmtI: begin
                enc_word[31:20] = imm[11:0];
                enc_err         = !fits_12;
            end
            FmtS: begin
                enc_word[31:25] = imm[11:5];
                enc_word[11:7]  = imm[4:0];
                enc_err         = !fits_12;
            end
            FmtB: begin
                enc_word[31]    = imm[12];
                enc_word[7]     = imm[11];
                enc_word[30:25] = imm[10:5];
                enc_word[11:8]  = imm[4:1];
                enc_err         = !fits_13 || imm[0];
            end
            FmtJ: begin
                enc_word[31]    = imm[20];
                enc_word[19:12] = imm[19:12];
                enc_word[20]    = imm[11];
                enc_word[30:21] = imm[10:1];
                enc_err         = !fits_21 || imm[0];
            end
            FmtU: begin
                enc_word[31:12] = imm[31:12];
                enc_err         = !low_zero;
            end
            default: begin
                // Unknown format: hand the base word back untouched
                enc_word = base_instr;
                enc_err  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Two-stage pipeline
    // ------------------------------------------------------------------
    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_instr_q, s1_instr_d;
    logic                 s1_err_q,   s1_err_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]     s2_instr_q, s2_instr_d;
    logic                 s2_err_q,   s2_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

    logic s2_advance;
    logic accept;
    logic s1_move;
    logic consume;

    // Handshake terms; in_ready depends only on state and out_ready
    always_comb begin
        s2_advance = !s2_valid_q || out_ready;
        in_ready   = !s1_valid_q || s2_advance;
        accept     = in_valid && in_ready;
        s1_move    = s1_valid_q && s2_advance;
        consume    = s2_valid_q && out_ready;
    end

    // Next-state for both stages; data registers only load on a transfer so
    // a stalled output holds stable
    always_comb begin
        s1_valid_d = accept || (s1_valid_q && !s2_advance);
        s1_instr_d = s1_instr_q;
        s1_err_d   = s1_err_q;
        if (accept) begin
            s1_instr_d = enc_word;
            s1_err_d   = enc_err;
        end

        s2_valid_d = s2_advance ? s1_valid_q : s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        if (s1_move) begin
            s2_instr_d = s1_instr_q;
            s2_err_d   = s1_err_q;
        end
    end

    // Saturating count of consumed results that carried range_err
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (consume && s2_err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // State registers; reset discards anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_instr_q <= '0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_instr_q <= s1_instr_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Stage 2 drives the outputs directly
    always_comb begin
        out_valid = s2_valid_q;
        instr_out = s2_instr_q;
        range_err = s2_err_q;
        err_count = err_cnt_q;
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors with literal
// expectations, backpressure, mid-flight reset and a randomized stream checked
// against a format-rule reference model.
module tb_imm_encoder;
    localparam int PER = 10;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    Immsrc = 3'd0;
    logic [31:0]   imm = 32'd0;
    logic [31:0]   base_instr = 32'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   instr_out;
    logic          range_err;
    logic [CW-1:0] err_count;

    imm_encoder #(.WIDTH(32), .ERR_CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Immsrc     (Immsrc),
        .imm        (imm),
        .base_instr (base_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr_out  (instr_out),
        .range_err  (range_err),
        .err_count  (err_count)
    );

    always #(PER / 2) clk = ~clk;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
        bit          has_lit;
        logic [31:0] lit_instr;
        logic        lit_err;
        longint      acc;
    } entry_t;

    entry_t q[$];
    int vectors = 0;
    int miscompares = 0;

    bit          cur_lit = 1'b0;
    logic [31:0] cur_lit_instr = 32'd0;
    logic        cur_lit_err = 1'b0;
    int          rmode = 0;
    time         bp_base = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] scatter(input logic [31:0] w, input logic [31:0] v,
                                            input int ilo, input int slo, input int len);
        for (int k = 0; k < len; k++) w[ilo + k] = v[slo + k];
        return w;
    endfunction

    function automatic logic [31:0] model_instr(input logic [2:0] s, input logic [31:0] v,
                                                input logic [31:0] b);
        logic [31:0] w;
        w = b;
        case (s)
            3'd0: w = scatter(w, v, 20, 0, 12);
            3'd1: begin
                w = scatter(w, v, 25, 5, 7);
                w = scatter(w, v, 7, 0, 5);
            end
            3'd2: begin
                w = scatter(w, v, 31, 12, 1);
                w = scatter(w, v, 7, 11, 1);
                w = scatter(w, v, 25, 5, 6);
                w = scatter(w, v, 8, 1, 4);
            end
            3'd3: begin
                w = scatter(w, v, 31, 20, 1);
                w = scatter(w, v, 12, 12, 8);
                w = scatter(w, v, 20, 11, 1);
                w = scatter(w, v, 21, 1, 10);
            end
            3'd4: w = scatter(w, v, 12, 12, 20);
            default: w = b;
        endcase
        return w;
    endfunction

    function automatic bit model_err(input logic [2:0] s, input logic [31:0] v);
        int signed sv;
        sv = $signed(v);
        case (s)
            3'd0, 3'd1: return !(sv >= -2048 && sv <= 2047);
            3'd2:       return !(sv >= -4096 && sv <= 4095 && (v % 2) == 0);
            3'd3:       return !(sv >= -1048576 && sv <= 1048575 && (v % 2) == 0);
            3'd4:       return (v % 4096) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    // Standard RV32I decode-side immediate extraction
    function automatic logic [31:0] decode(input logic [2:0] s, input logic [31:0] i);
        case (s)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4:    return {i[31:12], 12'h000};
            default: return i;
        endcase
    endfunction

    // ---------------- compare process ----------------
    longint        ncyc = 0;
    logic [CW-1:0] mcnt = '0;

    always @(negedge clk) begin
        bit     exp_ready;
        bit     exp_ov;
        entry_t e;
        if (rst) begin
            q.delete();
            mcnt = '0;
        end else begin
            exp_ready = !(q.size() >= 2 && !out_ready);
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            exp_ov = 1'b0;
            if (q.size() > 0) exp_ov = (ncyc - q[0].acc) >= 2;
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            if (out_valid && exp_ov) begin
                check("instr_out", instr_out, q[0].exp_instr);
                check("range_err", 32'(range_err), 32'(q[0].exp_err));
                if (!q[0].exp_err) check("round_trip", decode(q[0].src, instr_out), q[0].imm);
                if (q[0].has_lit) begin
                    check("lit_instr", instr_out, q[0].lit_instr);
                    check("lit_err", 32'(range_err), 32'(q[0].lit_err));
                end
            end
            check("err_count", 32'(err_count), 32'(mcnt));
            if (out_valid && out_ready && exp_ov) begin
                if (q[0].exp_err && mcnt != {CW{1'b1}}) mcnt = mcnt + 1'b1;
                void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                e.src       = Immsrc;
                e.imm       = imm;
                e.exp_instr = model_instr(Immsrc, imm, base_instr);
                e.exp_err   = model_err(Immsrc, imm);
                e.has_lit   = cur_lit;
                e.lit_instr = cur_lit_instr;
                e.lit_err   = cur_lit_err;
                e.acc       = ncyc;
                q.push_back(e);
            end
        end
        ncyc++;
    end

    // ---------------- out_ready driver ----------------
    always begin
        longint rel;
        @(posedge clk);
        #1;
        rel = longint'(($time - bp_base) / PER);
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom % 4) != 0;
            2:       out_ready = !(rel >= 3 && rel <= 7);
            default: out_ready = 1'b0;
        endcase
    end

    // ---------------- request driver ----------------
    task automatic push(input logic [2:0] s, input logic [31:0] v, input logic [31:0] b,
                        input bit lit, input logic [31:0] li, input logic le);
        int waitc;
        waitc = 0;
        in_valid = 1'b1;
        Immsrc = s;
        imm = v;
        base_instr = b;
        cur_lit = lit;
        cur_lit_instr = li;
        cur_lit_err = le;
        #1;
        while (!in_ready) begin
            if (waitc > 1000) begin
                fail_now("accept_timeout");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #2;
            waitc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        cur_lit = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [2:0]  s;
        logic [31:0] val, fit, v;
        int          r, kind, waitc;
        time         t0;

        // Pin the model with hand-computed values
        check("pin_i", model_instr(3'd0, 32'hFFFF_FFFF, 32'h13), 32'hFFF0_0013);
        check("pin_b", model_instr(3'd2, 32'h0000_0800, 32'h63), 32'h0000_00E3);
        check("pin_j", model_instr(3'd3, 32'hFFFF_FFFE, 32'h6F), 32'hFFFF_F06F);
        check("pin_u", model_instr(3'd4, 32'h1234_5000, 32'h37), 32'h1234_5037);
        check("pin_s", model_instr(3'd1, 32'hFFFF_F801, 32'h23), 32'h8000_00A3);
        check("pin_err_i_lo", 32'(model_err(3'd0, 32'hFFFF_F800)), 32'd0);
        check("pin_err_i_hi", 32'(model_err(3'd0, 32'h0000_0800)), 32'd1);
        check("pin_err_b", 32'(model_err(3'd2, 32'h0000_1001)), 32'd1);
        check("pin_err_j", 32'(model_err(3'd3, 32'h0010_0000)), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr_out", instr_out, 32'd0);
        check("rst_range_err", 32'(range_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors with literal expectations
        rmode = 0;
        push(3'd0, 32'hFFFF_FFFF, 32'h13, 1, 32'hFFF0_0013, 1'b0);
        push(3'd2, 32'h0000_0800, 32'h63, 1, 32'h0000_00E3, 1'b0);
        push(3'd2, 32'h0000_1001, 32'h63, 1, 32'h8000_0063, 1'b1);
        push(3'd3, 32'hFFFF_FFFE, 32'h6F, 1, 32'hFFFF_F06F, 1'b0);
        push(3'd3, 32'h0010_0000, 32'h6F, 1, 32'h8000_006F, 1'b1);
        push(3'd4, 32'h1234_5000, 32'h37, 1, 32'h1234_5037, 1'b0);
        push(3'd4, 32'h1234_5001, 32'h37, 1, 32'h1234_5037, 1'b1);
        push(3'd7, 32'hDEAD_BEEF, 32'h37, 1, 32'h0000_0037, 1'b1);
        push(3'd1, 32'hFFFF_F801, 32'h23, 1, 32'h8000_00A3, 1'b0);
        idle(4);

        // Backpressure: output stalled for a window while streaming
        bp_base = $time;
        rmode = 2;
        for (int i = 0; i < 10; i++) push(3'd0, 32'(i * 3 - 5), 32'h0000_0013, 0, 32'd0, 1'b0);
        idle(10);

        // Back-to-back throughput with the sink always ready
        rmode = 0;
        idle(2);
        t0 = $time;
        for (int i = 0; i < 10; i++) push(3'd0, 32'(i), 32'h0000_0093, 0, 32'd0, 1'b0);
        check("throughput_cycles", 32'(($time - t0) / PER), 32'd10);
        idle(4);

        // Reset with two entries in flight
        rmode = 3;
        idle(1);
        push(3'd2, 32'h0000_1001, 32'h63, 0, 32'd0, 1'b0);
        push(3'd4, 32'h0000_0001, 32'h37, 0, 32'd0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        check("midrst_instr_out", instr_out, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        rmode = 0;
        @(posedge clk);
        #1;
        idle(6);

        // Randomized stream
        rmode = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom % 4 == 0) idle(1);
            r = int'($urandom % 16);
            s = (r < 13) ? 3'(r % 5) : 3'(5 + r % 3);
            val = $urandom;
            case (s)
                3'd0, 3'd1: fit = {{20{val[11]}}, val[11:0]};
                3'd2:       fit = {{19{val[12]}}, val[12:1], 1'b0};
                3'd3:       fit = {{11{val[20]}}, val[20:1], 1'b0};
                3'd4:       fit = {val[31:12], 12'h000};
                default:    fit = val;
            endcase
            kind = int'($urandom % 4);
            if (kind == 0) v = val;
            else if (kind == 3) v = fit ^ (32'h1 << ($urandom % 32));
            else v = fit;
            push(s, v, $urandom, 0, 32'd0, 1'b0);
        end
        in_valid = 1'b0;
        rmode = 0;
        waitc = 0;
        while (q.size() != 0 && waitc < 100) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        if (q.size() != 0) fail_now("drain_timeout");
        idle(3);
        check("err_count_saturated", 32'(err_count), 32'(8'hFF));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
